mem_arbiter: RTL and testbench

- Two-requester controller that shares one aligned_ram instance between instruction fetch (port 0, read-only) and data load/store (port 1, read/write).
- Arbitrates round-robin and sequences each access as a fixed two-phase transaction.
- Pre-checks alignment so misaligned writes never reach memory.
- Returns read data and error status to the winning requester.
- Sits between core front-end/LSU and the RAM; the RAM's tri-state data bus is split here into mem_wdata/mem_rdata plus mem_oe.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one aligned RAM between an
// instruction-fetch port (0, read-only) and a load/store port (1).
// Every access is a fixed two-phase transaction: IDLE arbitrates and latches
// the winning request, BUSY drives the RAM and captures the response.
// Misaligned writes are filtered here so they never reach the RAM.
module mem_arbiter #(
    parameter int addr_width = 32,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [addr_width-1:0] req0_addr,
    input  logic [1:0]            req0_asize,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [data_width-1:0] rsp0_rdata,
    output logic                  rsp0_err,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [addr_width-1:0] req1_addr,
    input  logic [1:0]            req1_asize,
    input  logic [data_width-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [data_width-1:0] rsp1_rdata,
    output logic                  rsp1_err,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [1:0]            mem_asize,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    output logic                  mem_oe,
    input  logic [data_width-1:0] mem_rdata,
    input  logic                  mem_alignerr
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                state, state_next;
    logic                  ptr;          // port that wins a tie
    logic                  lat_port;     // port owning the transaction in flight
    logic                  lat_we;
    logic [addr_width-1:0] lat_addr;
    logic [1:0]            lat_asize;
    logic [data_width-1:0] lat_wdata;
    logic                  grant0, grant1;
    logic                  misaligned;
    logic                  acc_err;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Alignment/size check on the latched request
    always_comb begin
        misaligned = 1'b0;
        case (lat_asize)
            2'd1:    misaligned = lat_addr[0];
            2'd2:    misaligned = |lat_addr[1:0];
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Arbitration, next state and RAM strobes
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                grant0 = req0_valid & (~req1_valid | ~ptr);
                grant1 = req1_valid & (~req0_valid |  ptr);
                if (grant0 | grant1) state_next = BUSY;
            end
            BUSY: begin
                mem_re     = ~lat_we;
                mem_we     = lat_we & ~misaligned;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted, even if a requester is valid.
    assign req0_ready = grant0 & ~rst;
    assign req1_ready = grant1 & ~rst;
    assign mem_oe     = mem_we;
    assign mem_addr   = lat_addr;
    assign mem_asize  = lat_asize;
    assign mem_wdata  = lat_wdata;
    assign acc_err    = misaligned | mem_alignerr;

    // Request latch and round-robin pointer, updated on a handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 1'b0;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_asize <= '0;
            lat_wdata <= '0;
        end else if (grant0 | grant1) begin
            lat_port  <= grant1;
            lat_we    <= grant1 & req1_we;
            lat_addr  <= grant1 ? req1_addr  : req0_addr;
            lat_asize <= grant1 ? req1_asize : req0_asize;
            lat_wdata <= grant1 ? req1_wdata : '0;
            if (req0_valid & req1_valid) ptr <= ~ptr;
        end
    end

    // Response capture at the edge that ends BUSY; data/err hold until the next response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (state == BUSY) begin
                if (lat_port) begin
                    rsp1_valid <= 1'b1;
                    rsp1_err   <= acc_err;
                    rsp1_rdata <= (lat_we | acc_err) ? '0 : mem_rdata;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_err   <= acc_err;
                    rsp0_rdata <= acc_err ? '0 : mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte-array RAM stand-in on the memory side, a
// transaction-level reference model that predicts grants and responses, and a
// scoreboard monitor that checks each response when the DUT presents it.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [31:0] req0_addr = '0, req1_addr = '0, req1_wdata = '0;
    logic [1:0]  req0_asize = '0, req1_asize = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_re, mem_we, mem_oe, mem_alignerr;
    logic [1:0]  mem_asize;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.addr_width(32), .data_width(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_asize(req0_asize),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_asize(req1_asize),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_re(mem_re), .mem_we(mem_we), .mem_asize(mem_asize), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_rdata(mem_rdata), .mem_alignerr(mem_alignerr)
    );

    typedef struct {
        logic        vld;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  asize;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    req_t       pend [2];
    exp_t       q0 [$];
    exp_t       q1 [$];
    exp_t       mx;
    logic [7:0] ram [256];
    logic [7:0] ref_mem [256];
    logic [7:0] seed [256];
    logic       ram_load = 1'b1;
    int         errors = 0, checks = 0, cyc = 0, we_seen = 0, we_exp = 0;
    logic       mptr = 1'b0, mbusy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic mis(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] v;
        int n;
        v = '0;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(a[7:0]) + i) % 256];
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM stand-in: combinational read, write committed at the clock edge.
    logic [7:0]  ra;
    logic [31:0] rword;
    always_comb begin
        ra           = mem_addr[7:0];
        rword        = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};
        mem_alignerr = (mem_re || mem_we) && (mis(mem_addr, mem_asize) || mem_addr >= 32'h100);
        mem_rdata    = '0;
        if (mem_re && !mem_alignerr) begin
            case (mem_asize)
                2'd0:    mem_rdata = {24'h0, rword[7:0]};
                2'd1:    mem_rdata = {16'h0, rword[15:0]};
                default: mem_rdata = rword;
            endcase
        end
    end

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed[i];
        end else if (mem_we && mem_oe && mem_addr < 32'h100 && !mis(mem_addr, mem_asize)) begin
            ram[ra] <= mem_wdata[7:0];
            if (mem_asize != 2'd0) ram[ra + 8'd1] <= mem_wdata[15:8];
            if (mem_asize == 2'd2) begin
                ram[ra + 8'd2] <= mem_wdata[23:16];
                ram[ra + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    // Scoreboard monitor: pops the expected response whenever a port strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) we_seen++;
            if (mem_we || mem_oe) check("mem_oe_eq_mem_we", mem_oe, mem_we);
            if (rsp0_valid) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp0_unexpected: got rsp0_valid=1, want 0 (cycle %0d)", cyc);
                end else begin
                    mx = q0.pop_front();
                    check("rsp0_cycle", cyc, mx.due);
                    check("rsp0_rdata", rsp0_rdata, mx.rdata);
                    check("rsp0_err", rsp0_err, mx.err);
                end
            end
            if (rsp1_valid) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp1_unexpected: got rsp1_valid=1, want 0 (cycle %0d)", cyc);
                end else begin
                    mx = q1.pop_front();
                    check("rsp1_cycle", cyc, mx.due);
                    check("rsp1_rdata", rsp1_rdata, mx.rdata);
                    check("rsp1_err", rsp1_err, mx.err);
                end
            end
        end
    end

    // Reference model of one accepted transaction: predict response, update memory.
    task automatic model_exec(input int p);
        req_t r;
        exp_t x;
        logic w, e;
        r = pend[p];
        w = (p == 1) && r.we;
        e = mis(r.addr, r.asize) || (r.addr >= 32'h100);
        x.err   = e;
        x.due   = cyc + 2;
        x.rdata = (w || e) ? 32'h0 : ref_read(r.addr, r.asize);
        if (w && !mis(r.addr, r.asize)) we_exp++;
        if (w && !e) begin
            for (int i = 0; i < ((r.asize == 2'd0) ? 1 : (r.asize == 2'd1) ? 2 : 4); i++)
                ref_mem[int'(r.addr[7:0]) + i] = r.wdata[8*i +: 8];
        end
        if (p == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // One clock: drive pending requests, predict/check ready, advance the model.
    task automatic tick(input bit commit = 1'b1);
        logic g0, g1;
        req0_valid = pend[0].vld; req0_addr = pend[0].addr; req0_asize = pend[0].asize;
        req1_valid = pend[1].vld; req1_we = pend[1].we; req1_addr = pend[1].addr;
        req1_asize = pend[1].asize; req1_wdata = pend[1].wdata;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!mbusy) begin
            if (pend[0].vld && (!pend[1].vld || mptr == 1'b0)) g0 = 1'b1;
            else if (pend[1].vld)                             g1 = 1'b1;
        end
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        if (commit && (g0 || g1)) model_exec(g0 ? 0 : 1);
        if ((g0 || g1) && pend[0].vld && pend[1].vld) mptr = ~mptr;
        mbusy = g0 || g1;
        @(posedge clk);
        #1;
        if (g0) pend[0].vld = 1'b0;
        if (g1) pend[1].vld = 1'b0;
    endtask

    task automatic arm(input int p, input logic we, input logic [31:0] addr,
                       input logic [1:0] asize, input logic [31:0] wdata);
        pend[p].vld   = 1'b1;
        pend[p].we    = (p == 1) ? we : 1'b0;
        pend[p].addr  = addr;
        pend[p].asize = asize;
        pend[p].wdata = (p == 1) ? wdata : 32'h0;
    endtask

    task automatic drain(input int n);
        pend[0].vld = 1'b0;
        pend[1].vld = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic go(input int p, input logic we, input logic [31:0] addr,
                      input logic [1:0] asize, input logic [31:0] wdata);
        arm(p, we, addr, asize, wdata);
        for (int i = 0; i < 20 && pend[p].vld; i++) tick();
        check("request_accepted", pend[p].vld, 1'b0);
        drain(3);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid,
                               rsp1_err, mem_re, mem_we, mem_asize, mem_oe}, 64'h0);
        check({tag, "_rsp_rdata"}, {rsp0_rdata, rsp1_rdata}, 64'h0);
        check({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 64'h0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        int          diffs, r;
        for (int i = 0; i < 256; i++) begin
            seed[i]    = 8'($urandom);
            ref_mem[i] = seed[i];
        end
        pend[0] = '{1'b0, 1'b0, 32'h0, 2'd0, 32'h0};
        pend[1] = '{1'b0, 1'b0, 32'h0, 2'd0, 32'h0};
        #1;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        ram_load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Write then read back, two address/data pairs
        go(1, 1'b1, 32'hc0, 2'd1, 32'hcafe);
        check("t1_mem_we_pulses", we_seen, we_exp);
        check("t1_rsp1_err", rsp1_err, 1'b0);
        go(0, 1'b0, 32'hc0, 2'd1, 32'h0);
        check("t1_rsp0_rdata", rsp0_rdata, 32'h0000cafe);
        go(1, 1'b1, 32'hdc, 2'd1, 32'h9876);
        go(0, 1'b0, 32'hdc, 2'd1, 32'h0);
        check("t1b_rsp0_rdata", rsp0_rdata, 32'h00009876);

        // Continuous contention: both valid on every cycle
        for (int i = 0; i < 10; i++) begin
            if (!pend[0].vld) arm(0, 1'b0, 32'hc0, 2'd2, 32'h0);
            if (!pend[1].vld) arm(1, 1'b0, 32'hdc, 2'd2, 32'h0);
            tick();
        end
        drain(3);

        // Misaligned word write must never reach the RAM
        r = we_seen;
        go(1, 1'b1, 32'hc2, 2'd2, 32'h12345678);
        check("mis_no_mem_we", we_seen, r);
        check("mis_rsp1_err", rsp1_err, 1'b1);
        go(0, 1'b0, 32'hc0, 2'd2, 32'h0);

        // Illegal access size
        go(0, 1'b0, 32'hc0, 2'd3, 32'h0);
        check("illegal_rsp0_err", rsp0_err, 1'b1);
        check("illegal_rsp0_rdata", rsp0_rdata, 32'h0);

        // Reset in the BUSY cycle of a write; first tie afterwards must go to port 0
        for (int i = 0; i < 6 && mptr == 1'b0; i++) begin
            if (!pend[0].vld) arm(0, 1'b0, 32'hc8, 2'd2, 32'h0);
            if (!pend[1].vld) arm(1, 1'b0, 32'hcc, 2'd2, 32'h0);
            tick();
        end
        drain(3);
        arm(1, 1'b1, 32'hc4, 2'd2, 32'hbeef);
        tick(1'b0);
        check("rst_write_accepted", pend[1].vld, 1'b0);
        req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        mbusy = 1'b0;
        mptr  = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        arm(0, 1'b0, 32'hc4, 2'd2, 32'h0);
        arm(1, 1'b0, 32'hdc, 2'd2, 32'h0);
        for (int i = 0; i < 10 && (pend[0].vld || pend[1].vld); i++) tick();
        drain(3);

        // Back-to-back reads from port 1 alone
        for (int k = 0; k < 4; k++) begin
            arm(1, 1'b0, 32'hc0 + 32'(4 * k), 2'd2, 32'h0);
            for (int i = 0; i < 4 && pend[1].vld; i++) tick();
        end
        drain(3);

        // Randomised traffic, including requesters that give up before ready
        for (int t = 0; t < 400; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p].vld) begin
                    if ($urandom_range(0, 1) == 1) begin
                        r  = int'($urandom_range(0, 9));
                        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                        ad = ($urandom_range(0, 15) == 0) ? 32'h100 + 32'($urandom_range(0, 15))
                                                          : 32'hc0 + 32'($urandom_range(0, 63));
                        if ($urandom_range(0, 3) != 0 && sz == 2'd1) ad[0] = 1'b0;
                        if ($urandom_range(0, 3) != 0 && sz == 2'd2) ad[1:0] = 2'b00;
                        arm(p, 1'($urandom_range(0, 1)), ad, sz, $urandom);
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    pend[p].vld = 1'b0;
                end
            end
            tick();
        end
        drain(4);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("mem_we_pulses", we_seen, we_exp);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) diffs++;
        check("ram_contents_diffs", diffs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
